gf233_mult_arbiter: RTL and testbench



---
 rtl/gf233_mult_arbiter.sv | 161 ++++++++++++++++
 tb/tb_gf233_mult_arbiter.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf233_mult_arbiter.sv
// gf233_mult_arbiter: round-robin sharing of one registered GF(2^233) multiplier.
// Optional GF233_ARB_PERF_EN adds perf_clr input and perf_ops/perf_busy counters.
module gf233_mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int M         = 233,
  parameter int MULT_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*M-1:0] req_a,
  input  logic [NREQ*M-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [M-1:0]      rsp_data,
  output logic [M-1:0]      mult_a,
  output logic [M-1:0]      mult_b,
  input  logic [M-1:0]      mult_c,
`ifdef GF233_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_busy,
`endif
  output logic              busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (MULT_WAIT > 1) ? $clog2(MULT_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_WAIT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] own_oh;
  logic [M-1:0]    win_a;
  logic [M-1:0]    win_b;
  logic            cnt_done;
  logic            xfer;
  logic            cap;

  assign cnt_done = (cnt == CNT_LAST);
  assign xfer     = (state == S_IDLE) && win_vld;
  assign cap      = (state == S_WAIT) && cnt_done;
  assign win_oh   = NREQ'(1) << win;
  assign own_oh   = NREQ'(1) << owner;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(last_grant) + 1 + k) % NREQ;
      if (!win_vld && req_valid[IW'(j)]) begin
        win_vld = 1'b1;
        win     = IW'(j);
      end
    end
  end

  // Select the winner's operand pair from the packed buses.
  always_comb begin
    win_a = req_a[int'(win)*M +: M];
    win_b = req_b[int'(win)*M +: M];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state: grant, hold operands for the wait window, one response cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (win_vld) state_nx = S_WAIT;
      S_WAIT:  if (cnt_done) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state: grant only in IDLE, busy otherwise.
  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE:  req_ready = win_vld ? win_oh : '0;
      S_WAIT:  busy = 1'b1;
      S_RESP:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Latch operands and ownership on transfer; count the wait window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a     <= '0;
      mult_b     <= '0;
      owner      <= '0;
      last_grant <= LAST_RST;
      cnt        <= '0;
    end else if (xfer) begin
      mult_a     <= win_a;
      mult_b     <= win_b;
      owner      <= win;
      last_grant <= win;
      cnt        <= '0;
    end else if (state == S_WAIT) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the product and pulse the owner's response for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (cap) begin
        rsp_valid <= own_oh;
        rsp_data  <= mult_c;
      end
    end
  end

`ifdef GF233_ARB_PERF_EN
  // Saturating operation and busy-cycle counters with synchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else if (perf_clr) begin
      perf_ops  <= '0;
      perf_busy <= '0;
    end else begin
      if (cap && (perf_ops != 32'hFFFF_FFFF))
        perf_ops <= perf_ops + 32'd1;
      if (busy && (perf_busy != 32'hFFFF_FFFF))
        perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gf233_mult_arbiter.sv
// tb_gf233_mult_arbiter: randomized self-checking bench for gf233_mult_arbiter.
// Includes a registered GF(2^233) multiplier model on the mult_* port.
module tb_gf233_mult_arbiter;

  localparam int NREQ = 4;
  localparam int M    = 233;
  localparam int MW   = 4;
  localparam logic [M-1:0] POLY = (M'(1) << 74) | M'(1);

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*M-1:0] req_a;
  logic [NREQ*M-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [M-1:0]      rsp_data;
  logic [M-1:0]      mult_a;
  logic [M-1:0]      mult_b;
  logic [M-1:0]      mult_c;
  logic              busy;
`ifdef GF233_ARB_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_ops;
  logic [31:0]       perf_busy;
`endif

  logic [M-1:0] opa [NREQ];
  logic [M-1:0] opb [NREQ];

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int mdl_last;

  gf233_mult_arbiter #(
    .NREQ(NREQ),
    .M(M),
    .MULT_WAIT(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .mult_a(mult_a),
    .mult_b(mult_b),
    .mult_c(mult_c),
`ifdef GF233_ARB_PERF_EN
    .perf_clr(perf_clr),
    .perf_ops(perf_ops),
    .perf_busy(perf_busy),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Polynomial-basis multiply mod x^233 + x^74 + 1.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] r;
    logic [M-1:0] t;
    r = '0;
    t = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ t;
      t = t[M-1] ? ((t << 1) ^ POLY) : (t << 1);
    end
    return r;
  endfunction

  // External multiplier: one register stage.
  always @(posedge clk) mult_c <= gf_mul(mult_a, mult_b);

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*M +: M] = opa[i];
      req_b[i*M +: M] = opb[i];
    end
  end

  function automatic logic [M-1:0] rnd_op();
    logic [M-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | M'($urandom());
    return r;
  endfunction

  // Reference arbiter: first valid requester after the last grant.
  function automatic int pick(input logic [NREQ-1:0] v);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (mdl_last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (req_ready != '0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mdl_last = NREQ - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) @(negedge clk);
    vec++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      errs++;
      $display("FAIL reset_ctl busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid);
    end
    vec++;
    if (mult_a !== '0 || mult_b !== '0 || rsp_data !== '0) begin
      errs++;
      $display("FAIL reset_data a=%h b=%h d=%h exp 0", mult_a, mult_b, rsp_data);
    end
    vec++;
    if (req_ready !== '0) begin
      errs++;
      $display("FAIL reset_ready got=%b exp=0", req_ready);
    end
    rst = 1'b0;
    mdl_last = NREQ - 1;
    req_valid = '1;
    #1;
    vec++;
    if (req_ready !== oh(pick(req_valid))) begin
      errs++;
      $display("FAIL reset_prio got=%b exp=%b", req_ready, oh(pick(req_valid)));
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int w;
    int bcnt;
    opa[0] = M'(2);
    opb[0] = M'(3);
    req_valid = 4'b0001;
    #1;
    w = pick(req_valid);
    vec++;
    if (req_ready !== oh(w)) begin
      errs++;
      $display("FAIL single_ready got=%b exp=%b", req_ready, oh(w));
    end
    @(negedge clk);
    mdl_last = w;
    req_valid = '0;
    opa[0] = rnd_op();
    opb[0] = rnd_op();
    bcnt = 0;
    for (int k = 0; k <= MW + 1; k++) begin
      if (busy === 1'b1) bcnt++;
      vec++;
      if (rsp_valid !== ((k == MW) ? oh(w) : '0)) begin
        errs++;
        $display("FAIL single_rsp_valid k=%0d got=%b", k, rsp_valid);
      end
      if (k < MW) begin
        vec++;
        if (mult_a !== M'(2) || mult_b !== M'(3)) begin
          errs++;
          $display("FAIL single_hold k=%0d a=%h b=%h exp 2/3", k, mult_a, mult_b);
        end
      end
      if (k == MW) begin
        vec++;
        if (rsp_data !== M'(6)) begin
          errs++;
          $display("FAIL single_data got=%h exp=6", rsp_data);
        end
      end
      @(negedge clk);
    end
    vec++;
    if (bcnt != MW + 1) begin
      errs++;
      $display("FAIL single_busy got=%0d exp=%0d", bcnt, MW + 1);
    end
  endtask

  task automatic test_withdraw();
    int w;
    bit ok;
    logic [M-1:0] exp;
    opa[1] = rnd_op();
    opb[1] = rnd_op();
    opa[3] = rnd_op();
    opb[3] = rnd_op();
    req_valid = 4'b1010;
    #1;
    for (int op = 0; op < 2; op++) begin
      wait_ready(ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL withdraw_timeout op=%0d", op);
      end
      w = pick(req_valid);
      vec++;
      if (req_ready !== oh(w)) begin
        errs++;
        $display("FAIL withdraw_grant op=%0d got=%b exp=%b", op, req_ready, oh(w));
      end
      exp = gf_mul(opa[w], opb[w]);
      @(negedge clk);
      mdl_last = w;
      req_valid[w] = 1'b0;
      for (int k = 0; k <= MW; k++) begin
        req_valid[2] = (k < MW);
        #1;
        vec++;
        if (rsp_valid !== ((k == MW) ? oh(w) : '0) || req_ready[2] !== 1'b0) begin
          errs++;
          $display("FAIL withdraw_rsp op=%0d k=%0d rv=%b rdy=%b", op, k, rsp_valid, req_ready);
        end
        if (k == MW) begin
          vec++;
          if (rsp_data !== exp) begin
            errs++;
            $display("FAIL withdraw_data got=%h exp=%h", rsp_data, exp);
          end
        end
        @(negedge clk);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reduction();
    int w;
    logic [M-1:0] exp;
    exp = (M'(1) << 74) | M'(1);
    opa[2] = M'(1) << 232;
    opb[2] = M'(2);
    req_valid = 4'b0100;
    #1;
    w = pick(req_valid);
    vec++;
    if (req_ready !== oh(w)) begin
      errs++;
      $display("FAIL red_ready got=%b exp=%b", req_ready, oh(w));
    end
    @(negedge clk);
    mdl_last = w;
    req_valid = '0;
    opa[2] = rnd_op();
    opb[2] = rnd_op();
    for (int k = 0; k <= MW; k++) begin
      if (k < MW) begin
        vec++;
        if (mult_a !== (M'(1) << 232) || mult_b !== M'(2)) begin
          errs++;
          $display("FAIL red_hold k=%0d a=%h b=%h", k, mult_a, mult_b);
        end
      end else begin
        vec++;
        if (rsp_valid !== oh(w) || rsp_data !== exp) begin
          errs++;
          $display("FAIL red_rsp rv=%b got=%h exp=%h", rsp_valid, rsp_data, exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit seen;
    logic [M-1:0] exp;
    opa[0] = rnd_op();
    opb[0] = rnd_op();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
      errs++;
      $display("FAIL midrst_ctl busy=%b rv=%b rdy=%b", busy, rsp_valid, req_ready);
    end
    vec++;
    if (mult_a !== '0 || mult_b !== '0 || rsp_data !== '0) begin
      errs++;
      $display("FAIL midrst_data a=%h b=%h d=%h exp 0", mult_a, mult_b, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_last = NREQ - 1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    vec++;
    if (seen) begin
      errs++;
      $display("FAIL midrst_ghost got=1 exp=0");
    end
    opa[0] = rnd_op();
    opb[0] = rnd_op();
    opa[1] = rnd_op();
    opb[1] = rnd_op();
    req_valid = 4'b0011;
    #1;
    w = pick(req_valid);
    vec++;
    if (req_ready !== oh(w)) begin
      errs++;
      $display("FAIL midrst_prio got=%b exp=%b", req_ready, oh(w));
    end
    exp = gf_mul(opa[w], opb[w]);
    @(negedge clk);
    mdl_last = w;
    req_valid = '0;
    repeat (MW) @(negedge clk);
    vec++;
    if (rsp_valid !== oh(w) || rsp_data !== exp) begin
      errs++;
      $display("FAIL midrst_rsp rv=%b got=%h exp=%h", rsp_valid, rsp_data, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int w;
    int prev;
    bit ok;
    logic [M-1:0] exp;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = rnd_op();
      opb[i] = rnd_op() | M'(i + 1);
    end
    req_valid = '1;
    #1;
    prev = 0;
    for (int op = 0; op < 2 * NREQ; op++) begin
      wait_ready(ok);
      vec++;
      if (!ok) begin
        errs++;
        $display("FAIL rr_timeout op=%0d", op);
      end
      w = pick(req_valid);
      vec++;
      if (req_ready !== oh(w) || w != op % NREQ) begin
        errs++;
        $display("FAIL rr_grant op=%0d got=%b exp=%b", op, req_ready, oh(op % NREQ));
      end
      if (op > 0) begin
        vec++;
        if (cyc - prev != MW + 2) begin
          errs++;
          $display("FAIL rr_spacing op=%0d got=%0d exp=%0d", op, cyc - prev, MW + 2);
        end
      end
      prev = cyc;
      exp = gf_mul(opa[w], opb[w]);
      @(negedge clk);
      mdl_last = w;
      repeat (MW) @(negedge clk);
      vec++;
      if (rsp_valid !== oh(w) || rsp_data !== exp) begin
        errs++;
        $display("FAIL rr_rsp op=%0d rv=%b got=%h exp=%h", op, rsp_valid, rsp_data, exp);
      end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

`ifdef GF233_ARB_PERF_EN
  task automatic test_perf();
    pulse_reset();
    perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opa[0] = rnd_op();
      opb[0] = rnd_op();
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = '0;
      repeat (MW + 1) @(negedge clk);
    end
    vec++;
    if (perf_ops !== 32'd3 || perf_busy !== 32'd15) begin
      errs++;
      $display("FAIL perf_count ops=%0d busy=%0d exp 3/15", perf_ops, perf_busy);
    end
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    vec++;
    if (perf_ops !== 32'd0 || perf_busy !== 32'd0) begin
      errs++;
      $display("FAIL perf_clr ops=%0d busy=%0d exp 0/0", perf_ops, perf_busy);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    mdl_last = NREQ - 1;
`ifdef GF233_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_withdraw();
    test_reduction();
    test_reset_mid();
    test_round_robin();
`ifdef GF233_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
